afe_seq_ctl: RTL and testbench
==============================

// Module: afe_seq_ctl
// PURPOSE
//   Parametrised AFE readout sequencer: successor to the fixed-timing AFE control FSM.
//   Drives one or more daisy-chained AFEs: IRST/STI, N_CLK shift clocks, SHR, INTG/DF_SM, SHS.
//   Timing, channel count and chain length come from parameters; adds runtime PGA, a
//   continuous-frame mode, BUSY/FRAME_DONE handshake and per-channel ADC strobes.
//   Sits between the system controller (SAMPLE_EN) and the ADS capture logic (CH_VALID/CH_IDX).
// PARAMETERS (all times in CLK_100M cycles, all >= 1)
//   T_STI      5     AFE_STI high time at start of IRST phase; must be <= T_IRST
//   T_IRST     10    AFE_IRST high time = length of IRST phase
//   T_HALF_CLK 65    AFE_CLK half period
//   N_CH       64    channels per AFE
//   N_AFE      1     AFEs in STI/STO daisy chain
//   CLK_EXTRA  3     extra AFE_CLK periods after N_CH*N_AFE; N_CLK = N_CH*N_AFE + CLK_EXTRA
//   T_SHR      5     AFE_SHR high time
//   T_WAIT_INTG 10   SHR low time before INTG
//   T_TFT      1400  AFE_DF_SM low time from INTG start; must be <= T_INTG
//   T_INTG     1450  AFE_INTG high time
//   T_WAIT_SHS 500   INTG low time before SHS
//   T_SHS      5     AFE_SHS high time
//   T_END      5     SHS low time before frame end
//   CW         16    timer/counter width; every T_* and N_CLK must fit
// PORTS
//   CLK_100M    in  1  system clock
//   CLK_RST     in  1  synchronous reset, active high
//   ADS_INIT_OK in  1  ADC ready; frame starts only when high
//   SAMPLE_EN   in  1  rising edge starts a frame; level keeps continuous mode running
//   CONT_MODE   in  1  1 = back-to-back frames while SAMPLE_EN && ADS_INIT_OK
//   PGA_SEL     in  3  gain code, latched onto AFE_PGA at each frame start
//   AFE_STO     in  1  token out of last AFE in chain
//   AFE_CLK, AFE_INTG, AFE_IRST, AFE_SHS, AFE_SHR, AFE_STI, AFE_DF_SM  out 1  AFE controls
//   AFE_PGA     out 3  registered gain code
//   AFE_PDZ, AFE_NAPZ, AFE_ENTRI, AFE_SMT_MD, AFE_INPUTZ  out 1  tied 1
//   BUSY        out 1  high for every cycle of a frame
//   FRAME_DONE  out 1  one-cycle pulse in last cycle of each frame
//   CH_VALID    out 1  one-cycle pulse coincident with each AFE_CLK rising edge
//   CH_IDX      out CW index of current AFE_CLK period, 0..N_CLK-1
//   STO_ERR     out 1  token check failure (see CONFIGURATION)
// BEHAVIOUR
//   Reset: all AFE controls 0 except AFE_DF_SM=1, AFE_PGA=3'b111; BUSY/FRAME_DONE/CH_VALID/STO_ERR=0,
//     CH_IDX=0, FSM=IDLE; SAMPLE_EN edge register resets to 1 (level high at release is no edge).
//   Reset mid-frame: all outputs return to reset values on that edge; no frame resumes.
//   All outputs registered. Start: at edge where FSM=IDLE, SAMPLE_EN=1, prev SAMPLE_EN=0,
//     ADS_INIT_OK=1 -> same edge sets BUSY, AFE_IRST, AFE_STI, AFE_PGA<=PGA_SEL.
//   FSM IDLE->IRST->CLK->SHR->INTG->SHS->(IRST | IDLE); phase lengths exact:
//     IRST  T_IRST: IRST high whole phase, STI high first T_STI cycles.
//     CLK   2*T_HALF_CLK*N_CLK: AFE_CLK rises in cycle 0 of each period, falls at T_HALF_CLK;
//           CH_VALID with each rise; CH_IDX increments at each rise after the first.
//     SHR   T_SHR+T_WAIT_INTG: SHR high first T_SHR cycles.
//     INTG  T_INTG+T_WAIT_SHS: INTG high first T_INTG, DF_SM low first T_TFT cycles.
//     SHS   T_SHS+T_END: SHS high first T_SHS; FRAME_DONE in final cycle.
//   Frame length L = sum of phases; BUSY high exactly L cycles per frame.
//   End: if CONT_MODE && SAMPLE_EN && ADS_INIT_OK, next cycle is IRST cycle 0 (BUSY stays 1,
//     PGA relatched); else IDLE, BUSY=0.
//   SAMPLE_EN edges while BUSY ignored, not queued. ADS_INIT_OK drop mid-frame: frame completes.
//   CONT_MODE sampled only at frame end. Timers wrap never: each clears at phase change.
// CONFIGURATION
//   AFE_STO_CHECK_EN defined: STO_ERR cleared at frame start; set (sticky to next start) at
//     CLK-phase end if AFE_STO was not sampled high at least once after CH_IDX reached
//     N_CH*N_AFE-1 within the CLK phase.
//   Not defined: STO_ERR tied 0, AFE_STO ignored, no check logic.
// TESTING (bench params: T_STI=2 T_IRST=4 T_HALF_CLK=3 N_CH=4 N_AFE=2 CLK_EXTRA=1 T_SHR=2
//   T_WAIT_INTG=3 T_TFT=8 T_INTG=10 T_WAIT_SHS=5 T_SHS=2 T_END=1 -> N_CLK=9, L=81)
//   single: ADS_INIT_OK=1, SAMPLE_EN 0->1, PGA_SEL=3'b010 -> BUSY 81 cycles, IRST 4, STI 2,
//     9 AFE_CLK periods of 6, CH_VALID x9 CH_IDX 0..8, SHR 2, INTG 10, DF_SM low 8, SHS 2,
//     FRAME_DONE 1 at cycle 81, AFE_PGA=010.
//   gating: ADS_INIT_OK=0 at SAMPLE_EN rise -> BUSY stays 0; SAMPLE_EN high out of reset -> no frame.
//   continuous: CONT_MODE=1, SAMPLE_EN held -> IRST rises every 81 cycles, 3 frames; drop SAMPLE_EN
//     in frame 3 -> frame 3 completes, IDLE.
//   retrigger/reset: SAMPLE_EN toggle at cycle 20 -> ignored; CLK_RST at cycle 40 -> next edge
//     all outputs at reset values, DF_SM=1, BUSY=0.
//   AFE_STO_CHECK_EN: STO pulse at CH_IDX=8 -> STO_ERR=0; no STO -> STO_ERR=1 after CLK phase,
//     cleared at next start.

Source files
------------

// File: rtl/afe_seq_ctl.sv
// Parametrised AFE readout sequencer: IRST/STI, shift clocks, SHR, INTG/DF_SM, SHS; optional STO token check under AFE_STO_CHECK_EN.
// Latency: frame starts on the edge that samples a qualified SAMPLE_EN rise; every output is registered.
// Backpressure: none; SAMPLE_EN edges are ignored while BUSY, ADS_INIT_OK only gates frame starts.
module afe_seq_ctl #(
    parameter int T_STI       = 5,
    parameter int T_IRST      = 10,
    parameter int T_HALF_CLK  = 65,
    parameter int N_CH        = 64,
    parameter int N_AFE       = 1,
    parameter int CLK_EXTRA   = 3,
    parameter int T_SHR       = 5,
    parameter int T_WAIT_INTG = 10,
    parameter int T_TFT       = 1400,
    parameter int T_INTG      = 1450,
    parameter int T_WAIT_SHS  = 500,
    parameter int T_SHS       = 5,
    parameter int T_END       = 5,
    parameter int CW          = 16
) (
    input  logic          CLK_100M,
    input  logic          CLK_RST,
    input  logic          ADS_INIT_OK,
    input  logic          SAMPLE_EN,
    input  logic          CONT_MODE,
    input  logic [2:0]    PGA_SEL,
    input  logic          AFE_STO,
    output logic          AFE_CLK,
    output logic          AFE_INTG,
    output logic          AFE_IRST,
    output logic          AFE_SHS,
    output logic          AFE_SHR,
    output logic          AFE_STI,
    output logic          AFE_DF_SM,
    output logic [2:0]    AFE_PGA,
    output logic          AFE_PDZ,
    output logic          AFE_NAPZ,
    output logic          AFE_ENTRI,
    output logic          AFE_SMT_MD,
    output logic          AFE_INPUTZ,
    output logic          BUSY,
    output logic          FRAME_DONE,
    output logic          CH_VALID,
    output logic [CW-1:0] CH_IDX,
    output logic          STO_ERR
);
    localparam int N_CLK = N_CH * N_AFE + CLK_EXTRA;

    localparam logic [CW-1:0] STI_LEN   = CW'(T_STI);
    localparam logic [CW-1:0] IRST_LAST = CW'(T_IRST - 1);
    localparam logic [CW-1:0] HALF_LEN  = CW'(T_HALF_CLK);
    localparam logic [CW-1:0] PER_LAST  = CW'(2 * T_HALF_CLK - 1);
    localparam logic [CW-1:0] IDX_LAST  = CW'(N_CLK - 1);
    localparam logic [CW-1:0] SHR_LEN   = CW'(T_SHR);
    localparam logic [CW-1:0] SHR_LAST  = CW'(T_SHR + T_WAIT_INTG - 1);
    localparam logic [CW-1:0] TFT_LEN   = CW'(T_TFT);
    localparam logic [CW-1:0] INTG_LEN  = CW'(T_INTG);
    localparam logic [CW-1:0] INTG_LAST = CW'(T_INTG + T_WAIT_SHS - 1);
    localparam logic [CW-1:0] SHS_LEN   = CW'(T_SHS);
    localparam logic [CW-1:0] SHS_LAST  = CW'(T_SHS + T_END - 1);

    typedef enum logic [2:0] {S_IDLE, S_IRST, S_CLK, S_SHR, S_INTG, S_SHS} state_t;

    state_t        state, nxt_state;
    logic [CW-1:0] tmr, nxt_tmr;
    logic [CW-1:0] idx, nxt_idx;
    logic          se_q;
    logic          start;
    logic          cont_go;
    logic          frame_start;

    assign start       = (state == S_IDLE) && SAMPLE_EN && !se_q && ADS_INIT_OK;
    assign cont_go     = CONT_MODE && SAMPLE_EN && ADS_INIT_OK;
    assign frame_start = (nxt_state == S_IRST) && (state != S_IRST);

    always_comb begin
        nxt_state = state;
        nxt_tmr   = tmr + 1'b1;
        nxt_idx   = idx;
        case (state)
            S_IDLE: begin
                nxt_tmr = '0;
                if (start) nxt_state = S_IRST;
            end
            S_IRST: if (tmr == IRST_LAST) begin
                nxt_state = S_CLK;
                nxt_tmr   = '0;
                nxt_idx   = '0;
            end
            // tmr spans one AFE_CLK period; idx counts periods
            S_CLK: if (tmr == PER_LAST) begin
                nxt_tmr = '0;
                if (idx == IDX_LAST) nxt_state = S_SHR;
                else                 nxt_idx   = idx + 1'b1;
            end
            S_SHR: if (tmr == SHR_LAST) begin
                nxt_state = S_INTG;
                nxt_tmr   = '0;
            end
            S_INTG: if (tmr == INTG_LAST) begin
                nxt_state = S_SHS;
                nxt_tmr   = '0;
            end
            S_SHS: if (tmr == SHS_LAST) begin
                nxt_state = cont_go ? S_IRST : S_IDLE;
                nxt_tmr   = '0;
            end
            default: begin
                nxt_state = S_IDLE;
                nxt_tmr   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the phase they describe
    always_ff @(posedge CLK_100M) begin
        if (CLK_RST) begin
            state      <= S_IDLE;
            tmr        <= '0;
            idx        <= '0;
            se_q       <= 1'b1;
            BUSY       <= 1'b0;
            FRAME_DONE <= 1'b0;
            CH_VALID   <= 1'b0;
            AFE_CLK    <= 1'b0;
            AFE_INTG   <= 1'b0;
            AFE_IRST   <= 1'b0;
            AFE_SHS    <= 1'b0;
            AFE_SHR    <= 1'b0;
            AFE_STI    <= 1'b0;
            AFE_DF_SM  <= 1'b1;
            AFE_PGA    <= 3'b111;
        end else begin
            state      <= nxt_state;
            tmr        <= nxt_tmr;
            idx        <= nxt_idx;
            se_q       <= SAMPLE_EN;
            BUSY       <= (nxt_state != S_IDLE);
            AFE_IRST   <= (nxt_state == S_IRST);
            AFE_STI    <= (nxt_state == S_IRST) && (nxt_tmr < STI_LEN);
            AFE_CLK    <= (nxt_state == S_CLK) && (nxt_tmr < HALF_LEN);
            CH_VALID   <= (nxt_state == S_CLK) && (nxt_tmr == '0);
            AFE_SHR    <= (nxt_state == S_SHR) && (nxt_tmr < SHR_LEN);
            AFE_INTG   <= (nxt_state == S_INTG) && (nxt_tmr < INTG_LEN);
            AFE_DF_SM  <= !((nxt_state == S_INTG) && (nxt_tmr < TFT_LEN));
            AFE_SHS    <= (nxt_state == S_SHS) && (nxt_tmr < SHS_LEN);
            FRAME_DONE <= (nxt_state == S_SHS) && (nxt_tmr == SHS_LAST);
            if (frame_start) AFE_PGA <= PGA_SEL;
        end
    end

    assign CH_IDX     = idx;
    assign AFE_PDZ    = 1'b1;
    assign AFE_NAPZ   = 1'b1;
    assign AFE_ENTRI  = 1'b1;
    assign AFE_SMT_MD = 1'b1;
    assign AFE_INPUTZ = 1'b1;

`ifdef AFE_STO_CHECK_EN
    localparam logic [CW-1:0] TOK_IDX = CW'(N_CH * N_AFE - 1);

    logic sto_seen;
    logic sto_hit;

    assign sto_hit = (state == S_CLK) && (idx >= TOK_IDX) && AFE_STO;

    // The sample taken in the last CLK cycle still counts towards the verdict
    always_ff @(posedge CLK_100M) begin
        if (CLK_RST) begin
            sto_seen <= 1'b0;
            STO_ERR  <= 1'b0;
        end else if (frame_start) begin
            sto_seen <= 1'b0;
            STO_ERR  <= 1'b0;
        end else begin
            if (sto_hit) sto_seen <= 1'b1;
            if ((state == S_CLK) && (nxt_state == S_SHR)) STO_ERR <= !(sto_seen || sto_hit);
        end
    end
`else
    wire unused_sto = AFE_STO;
    assign STO_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_afe_seq_ctl.sv
// Bench for afe_seq_ctl: directed steps plus random frames against a frame-offset reference model.
module tb_afe_seq_ctl;
    localparam int T_STI = 2, T_IRST = 4, T_HALF_CLK = 3, N_CH = 4, N_AFE = 2, CLK_EXTRA = 1;
    localparam int T_SHR = 2, T_WAIT_INTG = 3, T_TFT = 8, T_INTG = 10, T_WAIT_SHS = 5;
    localparam int T_SHS = 2, T_END = 1, CW = 16;
    localparam int N_CLK  = N_CH * N_AFE + CLK_EXTRA;
    localparam int PER    = 2 * T_HALF_CLK;
    localparam int O_CLK  = T_IRST;
    localparam int O_SHR  = O_CLK + PER * N_CLK;
    localparam int O_INTG = O_SHR + T_SHR + T_WAIT_INTG;
    localparam int O_SHS  = O_INTG + T_INTG + T_WAIT_SHS;
    localparam int L      = O_SHS + T_SHS + T_END;
`ifdef AFE_STO_CHECK_EN
    localparam bit STO_CHK = 1'b1;
`else
    localparam bit STO_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, ads_ok, se, cont, sto;
    logic [2:0] pga_sel;
    logic afe_clk, afe_intg, afe_irst, afe_shs, afe_shr, afe_sti, afe_df_sm;
    logic [2:0] afe_pga;
    logic pdz, napz, entri, smt_md, inputz;
    logic busy, frame_done, ch_valid, sto_err;
    logic [CW-1:0] ch_idx;

    always #5 clk = ~clk;

    afe_seq_ctl #(
        .T_STI(T_STI), .T_IRST(T_IRST), .T_HALF_CLK(T_HALF_CLK), .N_CH(N_CH), .N_AFE(N_AFE),
        .CLK_EXTRA(CLK_EXTRA), .T_SHR(T_SHR), .T_WAIT_INTG(T_WAIT_INTG), .T_TFT(T_TFT),
        .T_INTG(T_INTG), .T_WAIT_SHS(T_WAIT_SHS), .T_SHS(T_SHS), .T_END(T_END), .CW(CW)
    ) dut (
        .CLK_100M(clk), .CLK_RST(rst), .ADS_INIT_OK(ads_ok), .SAMPLE_EN(se), .CONT_MODE(cont),
        .PGA_SEL(pga_sel), .AFE_STO(sto),
        .AFE_CLK(afe_clk), .AFE_INTG(afe_intg), .AFE_IRST(afe_irst), .AFE_SHS(afe_shs),
        .AFE_SHR(afe_shr), .AFE_STI(afe_sti), .AFE_DF_SM(afe_df_sm), .AFE_PGA(afe_pga),
        .AFE_PDZ(pdz), .AFE_NAPZ(napz), .AFE_ENTRI(entri), .AFE_SMT_MD(smt_md), .AFE_INPUTZ(inputz),
        .BUSY(busy), .FRAME_DONE(frame_done), .CH_VALID(ch_valid), .CH_IDX(ch_idx), .STO_ERR(sto_err)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: frame membership and cycle offset within the frame
    bit       m_in, m_prev, m_err, m_seen, m_idx0;
    int       m_off;
    logic [2:0] m_pga;
    int       sto_mode;
    int       cnt_busy, cnt_valid, cnt_irst, cnt_irst_rise;
    logic     prev_irst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_cnt();
        cnt_busy = 0; cnt_valid = 0; cnt_irst = 0; cnt_irst_rise = 0;
    endtask

    task automatic model_step();
        if (rst) begin
            m_in = 0; m_off = 0; m_prev = 1; m_pga = 3'b111; m_err = 0; m_seen = 0; m_idx0 = 1;
        end else begin
            if (m_in) begin
                if (STO_CHK && m_off >= O_CLK && m_off < O_SHR &&
                    (m_off - O_CLK) / PER >= N_CH * N_AFE - 1 && sto)
                    m_seen = 1;
                if (STO_CHK && m_off == O_SHR - 1) m_err = !m_seen;
                if (m_off == L - 1) begin
                    if (cont && se && ads_ok) begin
                        m_off = 0; m_pga = pga_sel; m_seen = 0; m_err = 0;
                    end else begin
                        m_in = 0;
                    end
                end else begin
                    m_off++;
                end
            end else if (se && !m_prev && ads_ok) begin
                m_in = 1; m_off = 0; m_pga = pga_sel; m_seen = 0; m_err = 0; m_idx0 = 0;
            end
            m_prev = se;
        end
    endtask

    task automatic compare();
        logic e_clk, e_intg, e_irst, e_shs, e_shr, e_sti, e_df, e_done, e_valid;
        int   c;
        bit   idx_known;
        int   e_idx;
        e_clk = 0; e_intg = 0; e_irst = 0; e_shs = 0; e_shr = 0; e_sti = 0; e_df = 1;
        e_done = 0; e_valid = 0; idx_known = m_idx0; e_idx = 0;
        if (m_in) begin
            if (m_off < O_CLK) begin
                e_irst = 1; e_sti = (m_off < T_STI);
            end else if (m_off < O_SHR) begin
                c = m_off - O_CLK;
                e_clk = (c % PER) < T_HALF_CLK; e_valid = (c % PER) == 0;
                e_idx = c / PER; idx_known = 1;
            end else if (m_off < O_INTG) begin
                e_shr = (m_off - O_SHR) < T_SHR;
            end else if (m_off < O_SHS) begin
                c = m_off - O_INTG;
                e_intg = c < T_INTG; e_df = !(c < T_TFT);
            end else begin
                c = m_off - O_SHS;
                e_shs = c < T_SHS; e_done = (c == T_SHS + T_END - 1);
            end
        end
        chk("busy", busy, m_in);
        chk("ctl{clk,intg,irst,shs,shr,sti,dfsm}",
            {afe_clk, afe_intg, afe_irst, afe_shs, afe_shr, afe_sti, afe_df_sm},
            {e_clk, e_intg, e_irst, e_shs, e_shr, e_sti, e_df});
        chk("strobe{done,valid}", {frame_done, ch_valid}, {e_done, e_valid});
        chk("pga", afe_pga, m_pga);
        chk("tie_offs", {pdz, napz, entri, smt_md, inputz}, 5'h1f);
        chk("sto_err", sto_err, m_err);
        if (idx_known) chk("ch_idx", ch_idx, e_idx);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
        cnt_busy  += int'(busy);
        cnt_valid += int'(ch_valid);
        cnt_irst  += int'(afe_irst);
        if (afe_irst && !prev_irst) cnt_irst_rise++;
        prev_irst = afe_irst;
        case (sto_mode)
            1:       sto = m_in && (m_off == O_CLK + (N_CLK - 1) * PER);
            2:       sto = ($urandom_range(0, 7) == 0);
            default: sto = 1'b0;
        endcase
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (!busy) break;
            tick();
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    initial begin
        rst = 1; ads_ok = 1; se = 1; cont = 0; pga_sel = 3'b000; sto = 0; sto_mode = 0;
        prev_irst = 0;
        clr_cnt();
        repeat (3) tick();
        chk("reset_dfsm", afe_df_sm, 1'b1);
        chk("reset_pga", afe_pga, 3'b111);
        rst = 0;
        repeat (10) tick();
        chk("se_high_out_of_reset", cnt_busy, 0);

        // single frame
        se = 0; tick();
        pga_sel = 3'b010; se = 1; clr_cnt();
        repeat (90) tick();
        chk("single_busy_len", cnt_busy, 81);
        chk("single_ch_valid", cnt_valid, 9);
        chk("single_irst_len", cnt_irst, 4);
        chk("single_pga", afe_pga, 3'b010);

        // gating by ADS_INIT_OK
        se = 0; ads_ok = 0; tick();
        se = 1; clr_cnt();
        repeat (10) tick();
        ads_ok = 1;
        repeat (5) tick();
        chk("gated_no_frame", cnt_busy, 0);

        // continuous mode, SAMPLE_EN dropped in third frame
        se = 0; tick();
        cont = 1; pga_sel = 3'b101; se = 1; clr_cnt();
        repeat (2 * 81 + 30) tick();
        se = 0;
        wait_idle(100);
        repeat (3) tick();
        chk("cont_irst_rises", cnt_irst_rise, 3);
        chk("cont_busy_len", cnt_busy, 243);

        // retrigger ignored, then reset mid-frame
        cont = 0; tick();
        se = 1; clr_cnt();
        repeat (20) tick();
        se = 0; tick();
        se = 1;
        repeat (18) tick();
        chk("retrig_irst_rises", cnt_irst_rise, 1);
        rst = 1; tick();
        rst = 0;
        chk("midreset_busy", busy, 1'b0);
        chk("midreset_dfsm", afe_df_sm, 1'b1);
        repeat (5) tick();

        // STO token: pulse in the last period, then none
        se = 0; sto_mode = 1; tick();
        se = 1;
        repeat (85) tick();
        chk("sto_pulse_err", sto_err, 1'b0);
        se = 0; sto_mode = 0; tick();
        se = 1;
        repeat (65) tick();
        chk("sto_missing_err", sto_err, STO_CHK);
        wait_idle(40);
        se = 0; tick();
        se = 1; tick(); tick();
        chk("sto_cleared_at_start", sto_err, 1'b0);
        wait_idle(100);

        // randomized frames
        for (int k = 0; k < 10; k++) begin
            sto_mode = 2;
            pga_sel = 3'($urandom_range(0, 7));
            cont = 1'($urandom_range(0, 1));
            ads_ok = ($urandom_range(0, 3) != 0);
            se = 0;
            repeat ($urandom_range(1, 4)) tick();
            se = 1;
            repeat ($urandom_range(10, 120)) tick();
            ads_ok = 1'($urandom_range(0, 1));
            se = 1'($urandom_range(0, 1));
            if (k == 6) begin
                rst = 1; tick(); rst = 0;
            end
            repeat ($urandom_range(10, 120)) tick();
            se = 0;
            wait_idle(200);
        end
        sto_mode = 0;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
